// File: rtl/seg7_scan_driver_if.sv
// Signal bundle between the stopwatch counter chain and the 7-segment scan driver.
// The counter side (master) supplies the packed BCD digits, decimal points and the
// blank/hold controls. The driver side (slave) returns the anode/segment pins and the
// frame marker.
interface seg7_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);

   logic [NUM_DIGITS*4-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    blank_in;
   logic                    hold;
   logic [NUM_DIGITS-1:0]   an;
   logic [6:0]              seg;
   logic                    dp;
   logic                    frame_start;

   modport master (
      output digits_in,
      output dp_in,
      output blank_in,
      output hold,
      input  an,
      input  seg,
      input  dp,
      input  frame_start
   );

   modport slave (
      input  digits_in,
      input  dp_in,
      input  blank_in,
      input  hold,
      output an,
      output seg,
      output dp,
      output frame_start
   );

endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment display driver. A prescaler decides how long each anode
// stays lit, a digit index walks the anodes, and a shadow copy of the digits is taken
// once per frame so the display never tears. All pins come straight from flops.
module seg7_scan_driver #(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_DIV   = 100000,
   parameter int BLANK_LEADING = 1,
   parameter int ACTIVE_LOW    = 1
) (
   input logic               clk,
   input logic               rst,
   seg7_scan_driver_if.slave bus
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);
   localparam logic          POL      = (ACTIVE_LOW != 0);

   logic [PW-1:0]           r_pcnt;
   logic [IW-1:0]           r_idx;
   logic [NUM_DIGITS*4-1:0] r_shadowDigits;
   logic [NUM_DIGITS-1:0]   r_shadowDp;
   logic                    r_frameStart;
   logic [NUM_DIGITS-1:0]   r_an;
   logic [6:0]              r_seg;
   logic                    r_dp;

   logic                    w_digitEnd;
   logic                    w_frameWrap;
   logic [3:0]              w_curNibble;
   logic                    w_curDp;
   logic                    w_curLeadBlank;
   logic [NUM_DIGITS-1:0]   w_anHigh;
   logic [NUM_DIGITS-1:0]   w_leadBlank;
   logic                    w_zeroRun;
   logic [6:0]              w_segHigh;

   // Active-high segment pattern {g,f,e,d,c,b,a}; anything that is not BCD shows a dash.
   function automatic logic [6:0] decodeBcd(input logic [3:0] nibble);
      logic [6:0] pattern;
      case (nibble)
         4'd0:    pattern = 7'h3F;
         4'd1:    pattern = 7'h06;
         4'd2:    pattern = 7'h5B;
         4'd3:    pattern = 7'h4F;
         4'd4:    pattern = 7'h66;
         4'd5:    pattern = 7'h6D;
         4'd6:    pattern = 7'h7D;
         4'd7:    pattern = 7'h07;
         4'd8:    pattern = 7'h7F;
         4'd9:    pattern = 7'h6F;
         default: pattern = 7'h40;
      endcase
      return pattern;
   endfunction

   assign w_digitEnd  = (r_pcnt == PCNT_MAX);
   assign w_frameWrap = w_digitEnd && (r_idx == IDX_MAX);

   // Prescaler and digit index: each digit is held for REFRESH_DIV cycles, then the index moves on.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcnt <= '0;
         r_idx  <= '0;
      end else if (w_digitEnd) begin
         r_pcnt <= '0;
         r_idx  <= w_frameWrap ? '0 : r_idx + IW'(1);
      end else begin
         r_pcnt <= r_pcnt + PW'(1);
      end
   end

   // Frame boundary: flag the first cycle of the new frame and refresh the shadow unless held for a lap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frameStart   <= 1'b0;
         r_shadowDigits <= '0;
         r_shadowDp     <= '0;
      end else begin
         r_frameStart <= w_frameWrap;
         if (w_frameWrap && !bus.hold) begin
            r_shadowDigits <= bus.digits_in;
            r_shadowDp     <= bus.dp_in;
         end
      end
   end

   // Leading-zero mask: walking down from the top digit, a digit is blank while everything above and including it is zero.
   always_comb begin
      w_zeroRun   = 1'b1;
      w_leadBlank = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         w_zeroRun      = w_zeroRun && (r_shadowDigits[4*k +: 4] == 4'd0);
         w_leadBlank[k] = (BLANK_LEADING != 0) && (k != 0) && w_zeroRun;
      end
   end

   // Select the digit currently being scanned and build its anode and segment patterns.
   always_comb begin
      w_curNibble    = 4'd0;
      w_curDp        = 1'b0;
      w_curLeadBlank = 1'b0;
      w_anHigh       = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IW'(k)) begin
            w_curNibble    = r_shadowDigits[4*k +: 4];
            w_curDp        = r_shadowDp[k];
            w_curLeadBlank = w_leadBlank[k];
            w_anHigh[k]    = 1'b1;
         end
      end
      w_segHigh = w_curLeadBlank ? 7'h00 : decodeBcd(w_curNibble);
   end

   // Registered pin stage; blank_in only gates the anodes, and polarity is applied last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an  <= {NUM_DIGITS{POL}};
         r_seg <= {7{POL}};
         r_dp  <= POL;
      end else begin
         r_an  <= (bus.blank_in ? '0 : w_anHigh) ^ {NUM_DIGITS{POL}};
         r_seg <= w_segHigh ^ {7{POL}};
         r_dp  <= w_curDp ^ POL;
      end
   end

   assign bus.an          = r_an;
   assign bus.seg         = r_seg;
   assign bus.dp          = r_dp;
   assign bus.frame_start = r_frameStart;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with 4 digits and a 4-cycle refresh divider. A reference
// model counts clock edges since reset and derives the scanned digit, frame boundary,
// shadow contents and pin levels from that count with plain arithmetic.
module tb_seg7_scan_driver;

   localparam int ND = 4;
   localparam int RD = 4;
   localparam int FRAME = ND * RD;

   logic clk;
   logic rst;
   int   assertCount;
   int   failCount;

   seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_driver #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_LEADING(1),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [6:0] refDecode(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'd0: p = 7'h3F;  4'd1: p = 7'h06;  4'd2: p = 7'h5B;  4'd3: p = 7'h4F;
         4'd4: p = 7'h66;  4'd5: p = 7'h6D;  4'd6: p = 7'h7D;  4'd7: p = 7'h07;
         4'd8: p = 7'h7F;  4'd9: p = 7'h6F;
         default: p = 7'h40;
      endcase
      return p;
   endfunction

   int         mCyc;
   logic [15:0] mDig;
   logic [3:0]  mDpS;
   logic [3:0]  mAn;
   logic [6:0]  mSeg;
   logic        mDp;
   logic        mFs;

   // Reference model: expected pin values after each edge, from the edge count since reset.
   always @(posedge clk or posedge rst) begin : refModel
      int          k;
      logic [15:0] upper;
      logic [6:0]  segOn;
      if (rst) begin
         mCyc <= 0;
         mDig <= 16'h0;
         mDpS <= 4'h0;
         mAn  <= 4'hF;
         mSeg <= 7'h7F;
         mDp  <= 1'b1;
         mFs  <= 1'b0;
      end else begin
         k     = (mCyc / RD) % ND;
         upper = mDig >> (4 * k);
         segOn = (k > 0 && upper == 16'h0) ? 7'h00 : refDecode(upper[3:0]);
         mSeg <= ~segOn;
         mDp  <= ~mDpS[k];
         mAn  <= bus.blank_in ? 4'hF : ~(4'b0001 << k);
         mFs  <= ((mCyc % FRAME) == FRAME - 1);
         if (((mCyc % FRAME) == FRAME - 1) && !bus.hold) begin
            mDig <= bus.digits_in;
            mDpS <= bus.dp_in;
         end
         mCyc <= mCyc + 1;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] anPat [4];
      anPat[0] = 4'b1110; anPat[1] = 4'b1101; anPat[2] = 4'b1011; anPat[3] = 4'b0111;
      rst = 1'b1;
      bus.digits_in = 16'h0000; bus.dp_in = 4'h0; bus.blank_in = 1'b0; bus.hold = 1'b0;
      tick(); tick();
      assertCount++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         failCount++;
         $display("[TB] FAIL reset_state: got an=%b seg=%h dp=%b fs=%b, want an=1111 seg=7f dp=1 fs=0",
                  bus.an, bus.seg, bus.dp, bus.frame_start);
      end
      rst = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         assertCount++;
         if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {mAn, mSeg, mDp, mFs}) begin
            failCount++;
            $display("[TB] FAIL reset_scan_model cyc %0d: got %b/%h/%b/%b want %b/%h/%b/%b", i,
                     bus.an, bus.seg, bus.dp, bus.frame_start, mAn, mSeg, mDp, mFs);
         end
         assertCount++;
         if (bus.an !== anPat[i/4] || bus.seg !== ((i < 4) ? 7'h40 : 7'h7F)) begin
            failCount++;
            $display("[TB] FAIL zero_scan cyc %0d: got an=%b seg=%h want an=%b seg=%h", i,
                     bus.an, bus.seg, anPat[i/4], (i < 4) ? 7'h40 : 7'h7F);
         end
      end
   endtask

   task automatic test_digits();
      logic [6:0] segLit [4];
      int         waited;
      int         fsCount;
      segLit[0] = 7'h19; segLit[1] = 7'h30; segLit[2] = 7'h24; segLit[3] = 7'h79;
      bus.digits_in = 16'h1234;
      waited = 0;
      do begin
         tick();
         waited++;
      end while (bus.frame_start !== 1'b1 && waited < 3 * FRAME);
      assertCount++;
      if (bus.frame_start !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL digits_wait_frame: frame_start=%b after %0d cycles, want 1", bus.frame_start, waited);
      end
      fsCount = 0;
      for (int j = 1; j <= FRAME; j++) begin
         tick();
         if (bus.frame_start === 1'b1) fsCount++;
         assertCount++;
         if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {mAn, mSeg, mDp, mFs}) begin
            failCount++;
            $display("[TB] FAIL digits_model cyc %0d: got %b/%h/%b/%b want %b/%h/%b/%b", j,
                     bus.an, bus.seg, bus.dp, bus.frame_start, mAn, mSeg, mDp, mFs);
         end
         if (((j - 1) % 4) == 1) begin
            assertCount++;
            if (bus.seg !== segLit[(j-1)/4]) begin
               failCount++;
               $display("[TB] FAIL digits_1234 digit %0d: seg=%h want %h", (j-1)/4, bus.seg, segLit[(j-1)/4]);
            end
         end
      end
      assertCount++;
      if (fsCount != 1) begin
         failCount++;
         $display("[TB] FAIL frame_start_rate: %0d pulses in %0d cycles, want 1", fsCount, FRAME);
      end
   endtask

   task automatic test_midframe();
      int waited;
      for (int i = 0; i < 6; i++) begin
         tick();
         assertCount++;
         if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {mAn, mSeg, mDp, mFs}) begin
            failCount++;
            $display("[TB] FAIL midframe_model pre cyc %0d: got %b/%h want %b/%h", i, bus.an, bus.seg, mAn, mSeg);
         end
      end
      bus.digits_in = 16'h5678;
      waited = 0;
      do begin
         tick();
         waited++;
         assertCount++;
         if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {mAn, mSeg, mDp, mFs}) begin
            failCount++;
            $display("[TB] FAIL midframe_model cyc %0d: got %b/%h want %b/%h", waited, bus.an, bus.seg, mAn, mSeg);
         end
      end while (bus.frame_start !== 1'b1 && waited < 3 * FRAME);
      assertCount++;
      if (bus.frame_start !== 1'b1 || bus.seg !== 7'h79) begin
         failCount++;
         $display("[TB] FAIL midframe_old_value: fs=%b seg=%h want fs=1 seg=79", bus.frame_start, bus.seg);
      end
      tick();
      assertCount++;
      if (bus.an !== 4'b1110 || bus.seg !== 7'h00) begin
         failCount++;
         $display("[TB] FAIL midframe_new_value: an=%b seg=%h want an=1110 seg=00", bus.an, bus.seg);
      end
   endtask

   task automatic test_hold();
      bus.hold = 1'b1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (i % 5 == 0) bus.digits_in = 16'($urandom);
         tick();
         assertCount++;
         if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {mAn, mSeg, mDp, mFs}) begin
            failCount++;
            $display("[TB] FAIL hold_frozen cyc %0d: got %b/%h want %b/%h", i, bus.an, bus.seg, mAn, mSeg);
         end
      end
      bus.hold = 1'b0;
      bus.digits_in = 16'h9090;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         assertCount++;
         if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {mAn, mSeg, mDp, mFs}) begin
            failCount++;
            $display("[TB] FAIL hold_release cyc %0d: got %b/%h want %b/%h", i, bus.an, bus.seg, mAn, mSeg);
         end
      end
   endtask

   task automatic test_blank_dp();
      logic [6:0] segLit [4];
      int         waited;
      segLit[0] = 7'h12; segLit[1] = 7'h3F; segLit[2] = 7'h7F; segLit[3] = 7'h7F;
      bus.digits_in = 16'h00A5;
      bus.dp_in = 4'b0100;
      waited = 0;
      do begin
         tick();
         waited++;
      end while (bus.frame_start !== 1'b1 && waited < 3 * FRAME);
      tick(); tick(); tick(); tick();
      waited = 0;
      do begin
         tick();
         waited++;
      end while (bus.frame_start !== 1'b1 && waited < 3 * FRAME);
      assertCount++;
      if (bus.frame_start !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL blank_dp_wait_frame: frame_start=%b, want 1", bus.frame_start);
      end
      for (int j = 1; j <= FRAME; j++) begin
         tick();
         assertCount++;
         if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {mAn, mSeg, mDp, mFs}) begin
            failCount++;
            $display("[TB] FAIL blank_dp_model cyc %0d: got %b/%h/%b want %b/%h/%b", j,
                     bus.an, bus.seg, bus.dp, mAn, mSeg, mDp);
         end
         assertCount++;
         if (bus.seg !== segLit[(j-1)/4] || bus.dp !== (((j-1)/4 == 2) ? 1'b0 : 1'b1)) begin
            failCount++;
            $display("[TB] FAIL blank_dp_00A5 digit %0d: seg=%h dp=%b want seg=%h dp=%b", (j-1)/4,
                     bus.seg, bus.dp, segLit[(j-1)/4], ((j-1)/4 == 2) ? 1'b0 : 1'b1);
         end
      end
   endtask

   task automatic test_blank_in();
      bus.digits_in = 16'h4321;
      bus.dp_in = 4'h0;
      tick(); tick(); tick(); tick(); tick(); tick();
      bus.blank_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         assertCount++;
         if (bus.an !== 4'hF || {bus.seg, bus.dp, bus.frame_start} !== {mSeg, mDp, mFs}) begin
            failCount++;
            $display("[TB] FAIL blank_in_anodes cyc %0d: an=%b seg=%h want an=1111 seg=%h", i, bus.an, bus.seg, mSeg);
         end
      end
      bus.blank_in = 1'b0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick();
         assertCount++;
         if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {mAn, mSeg, mDp, mFs}) begin
            failCount++;
            $display("[TB] FAIL blank_in_phase cyc %0d: got %b/%h/%b want %b/%h/%b", i,
                     bus.an, bus.seg, bus.frame_start, mAn, mSeg, mFs);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0)
            bus.digits_in = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
         if ($urandom_range(0, 5) == 0) bus.dp_in = 4'($urandom);
         if ($urandom_range(0, 20) == 0) bus.hold = ~bus.hold;
         bus.blank_in = ($urandom_range(0, 12) == 0);
         tick();
         assertCount++;
         if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {mAn, mSeg, mDp, mFs}) begin
            failCount++;
            $display("[TB] FAIL random_model cyc %0d: got %b/%h/%b/%b want %b/%h/%b/%b", i,
                     bus.an, bus.seg, bus.dp, bus.frame_start, mAn, mSeg, mDp, mFs);
         end
      end
      bus.hold = 1'b0;
      bus.blank_in = 1'b0;
   endtask

   task automatic test_reset_mid();
      bus.digits_in = 16'h0817;
      for (int i = 0; i < 2 * FRAME + 7; i++) tick();
      #2;
      rst = 1'b1;
      #1;
      assertCount++;
      if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         failCount++;
         $display("[TB] FAIL reset_async: got an=%b seg=%h dp=%b fs=%b, want 1111/7f/1/0",
                  bus.an, bus.seg, bus.dp, bus.frame_start);
      end
      tick();
      rst = 1'b0;
      tick();
      assertCount++;
      if (bus.an !== 4'b1110 || bus.seg !== 7'h40) begin
         failCount++;
         $display("[TB] FAIL reset_restart: an=%b seg=%h want an=1110 seg=40", bus.an, bus.seg);
      end
      for (int i = 0; i < 3 * FRAME; i++) begin
         tick();
         assertCount++;
         if ({bus.an, bus.seg, bus.dp, bus.frame_start} !== {mAn, mSeg, mDp, mFs}) begin
            failCount++;
            $display("[TB] FAIL reset_resume_model cyc %0d: got %b/%h/%b want %b/%h/%b", i,
                     bus.an, bus.seg, bus.frame_start, mAn, mSeg, mFs);
         end
      end
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      assertCount = 0;
      failCount   = 0;
      test_reset();
      test_digits();
      test_midframe();
      test_hold();
      test_blank_dp();
      test_blank_in();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
